// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants for the LM/SM fetch-stage expander: opcodes, IR field
// positions and the sequencer state encoding.
package lmsm_sequencer_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    // LSB positions of the instruction fields; ir[8] sits between base and mask unused.
    localparam int OPC_LSB  = 12;
    localparam int BASE_LSB = 9;
    localparam int MASK_LSB = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit priority encoder for the 8-bit LM/SM register mask.
module lmsm_prio_enc (
    input  logic [7:0] mask_i,
    output logic [2:0] idx_o,
    output logic       valid_o,
    output logic       one_hot_only_o
);

    logic found;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        idx_o = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mask_i[i] && !found) begin
                idx_o = 3'(i);
                found = 1'b1;
            end
        end
    end

    assign valid_o        = |mask_i;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign one_hot_only_o = valid_o && ((mask_i & (mask_i - 8'd1)) == 8'd0);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM expander: substitutes one LW/SW micro-op per set mask bit into the
// fetch-stage IR. Optional micro-op counter enabled by LMSM_PERF_CNT_EN.
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
#(
    parameter int W      = 16,
    parameter int MASK_W = 8,
    parameter int OFF_W  = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] ir_in,
    input  logic         ir_valid,
    input  logic         stall,
    input  logic         flush,
    output logic [W-1:0] new_ir_multi,
    output logic         ir_load_mux,
    output logic         pc_write,
    output logic         busy,
    output logic [15:0]  perf_cnt
);

    state_t            state_q, state_d;
    logic [MASK_W-1:0] rem_mask_q, rem_mask_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        base_q, base_d;

    logic [3:0]        ir_opc;
    logic [2:0]        ir_base;
    logic [MASK_W-1:0] ir_mask;
    logic [3:0]        ir_uop;
    logic              trigger;
    logic              unused_ir_bit;

    logic [MASK_W-1:0] enc_mask;
    logic [2:0]        enc_idx;
    logic              enc_valid;
    logic              enc_one_hot;

    assign ir_opc        = ir_in[OPC_LSB +: 4];
    assign ir_base       = ir_in[BASE_LSB +: 3];
    assign ir_mask       = ir_in[MASK_LSB +: MASK_W];
    assign unused_ir_bit = ir_in[8];
    assign ir_uop        = (ir_opc == OP_SM) ? OP_SW : OP_LW;
    assign trigger       = ir_valid && (ir_opc == OP_LM || ir_opc == OP_SM) && (ir_mask != '0);

    // One encoder serves both states: the fresh IR mask in IDLE, the remainder in EXPAND.
    assign enc_mask = (state_q == EXPAND) ? rem_mask_q : ir_mask;

    lmsm_prio_enc u_prio_enc (
        .mask_i         (enc_mask),
        .idx_o          (enc_idx),
        .valid_o        (enc_valid),
        .one_hot_only_o (enc_one_hot)
    );

    always_comb begin
        state_d      = state_q;
        rem_mask_d   = rem_mask_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        base_d       = base_q;
        new_ir_multi = '0;
        ir_load_mux  = 1'b0;
        pc_write     = 1'b1;
        busy         = 1'b0;

        if (flush) begin
            state_d    = IDLE;
            rem_mask_d = '0;
            cnt_d      = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger && enc_valid) begin
                        ir_load_mux  = 1'b1;
                        new_ir_multi = W'({ir_uop, enc_idx, ir_base, OFF_W'(3'd0)});
                        if (!enc_one_hot) begin
                            pc_write = 1'b0;
                            if (!stall) begin
                                state_d    = EXPAND;
                                rem_mask_d = ir_mask & (ir_mask - MASK_W'(1));
                                cnt_d      = 3'd1;
                                op_d       = ir_uop;
                                base_d     = ir_base;
                            end
                        end
                    end
                end
                EXPAND: begin
                    ir_load_mux  = 1'b1;
                    busy         = 1'b1;
                    new_ir_multi = W'({op_q, enc_idx, base_q, OFF_W'(cnt_q)});
                    if (enc_one_hot) begin
                        if (!stall) begin
                            state_d    = IDLE;
                            rem_mask_d = '0;
                            cnt_d      = 3'd0;
                        end
                    end else begin
                        pc_write = 1'b0;
                        if (!stall) begin
                            rem_mask_d = rem_mask_q & (rem_mask_q - MASK_W'(1));
                            cnt_d      = 3'(cnt_q + 3'd1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            // A frozen fetch stage must not advance the PC, whatever the sequencer wants.
            if (stall) pc_write = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_mask_q <= '0;
            cnt_q      <= 3'd0;
            op_q       <= 4'd0;
            base_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            base_q     <= base_d;
        end
    end

`ifdef LMSM_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (ir_load_mux && !stall && !flush && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_q <= 16'd0;
        else       perf_q <= perf_d;
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = 16'd0;
`endif

endmodule
